mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for MIPS MULT/MULTU/DIV/DIVU. Replaces the combinational multiplier that feeds the HI/LO registers.
- Takes rs/rt operands from the register file read ports and produces 32-bit HI/LO results for the HI/LO register pair.
- Exposes a start/busy/done handshake so the controller can stall PC update until the result is ready.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH split into hi/lo.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (rst==0 resets)
- start  input  1  one-cycle request; sampled only when not busy
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  input  WIDTH  rs operand (multiplicand/dividend); sampled with start
- b  input  WIDTH  rt operand (multiplier/divisor); sampled with start
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse; hi/lo valid from this cycle
- hi  output  WIDTH  mult: product[2W-1:W]; div: remainder
- lo  output  WIDTH  mult: product[W-1:0]; div: quotient
- div_by_zero  output  1  last completed divide had b==0; held until next accepted start

Behaviour:
- Reset (rst low, async): state IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0, internal count=0. Reset mid-operation aborts it and discards the result.
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE/DONE with start=1: latch op, |a|, |b|, sign flags; count=0; go to RUN.
  - DONE with start=0: go to IDLE.
  - RUN: one iteration per cycle; after WIDTH iterations go to FIX.
  - FIX: apply sign correction; write hi/lo at the edge ending FIX; go to DONE.
- Timing: start high in cycle 0. RUN occupies cycles 1..WIDTH. FIX is cycle WIDTH+1. DONE is cycle WIDTH+2 (done=1, busy=0). For WIDTH=32, done is in cycle 34.
- busy=1 exactly in RUN and FIX.
- start while busy is ignored, with no side effects.
- Back-to-back: start in the DONE cycle is accepted.
- hi/lo hold their last result until the next FIX edge; they do not change during RUN.
- Signed handling: signed ops use magnitudes. Unsigned ops treat operands as-is.
- Multiply: shift-add, 2*WIDTH accumulator, LSB-first on multiplier. Signed result is negated (2*WIDTH two's complement) when sign(a)!=sign(b).
- Divide: restoring, one quotient bit per cycle, MSB-first.
  - Signed: quotient negated when sign(a)!=sign(b); remainder takes the sign of a.
  - Invariant: a == q*b + r.
- b==0 on a divide: div_by_zero=1 at DONE; lo=all-ones, hi=a (raw operand); no sign correction; latency unchanged.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, div_by_zero=0.
- Operand changes on a/b/op after the start cycle have no effect.

Optional Feature:
- Macro: MULT_DIV_EARLY_OUT_EN.
- Defined:
  - Multiply terminates RUN early when the remaining unshifted multiplier bits are all zero.
  - Divide terminates early when b==0 (goes straight to FIX).
  - Minimum latency: start cycle 0, done in cycle 3.
  - Results are identical to the non-early version.
- Undefined: fixed latency WIDTH+2 for every operation.
- The bench checks results for both builds. It checks exact latency only without the macro, and latency <= WIDTH+2 with it.

Decomposition:
- Package mult_div_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state encoding: S_IDLE, S_RUN, S_FIX, S_DONE
  - default WIDTH constant
- One sub-module: mult_div_step. It is combinational and does one iteration given accumulator, operand and mode. It returns the next accumulator, shifted operand and quotient bit, so the top module is only FSM, counter and registers.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001, busy high cycles 1..33.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=-7, b=2 issued in the DONE cycle -> accepted, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> div_by_zero=1, lo=0xFFFFFFFF, hi=100; next MULTU 2*3 clears div_by_zero, lo=6, hi=0.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- start re-pulsed in cycle 10 with a different op, and rst pulsed low in cycle 20 of a fresh MULTU -> cycle-10 start ignored; after the reset pulse, busy=0, hi=lo=0, no done pulse; a new start completes normally.
- Random 10k ops, all four opcodes against a reference model, including a/b in {0, 1, -1, 0x7FFFFFFF, 0x80000000} -> all hi/lo match.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared encodings and control bundle for the iterative MIPS multiply/divide unit.
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // Per-operation flags captured with start and consumed in FIX.
    typedef struct packed {
        logic is_div;
        logic b_zero;
        logic neg_res;
        logic neg_rem;
    } ctl_t;

    function automatic logic op_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_step.sv
// One combinational iteration: shift-add multiply (LSB-first) or restoring divide (MSB-first).
module mult_div_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [2*WIDTH-1:0]   mc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [2*WIDTH-1:0]   mc_o,
    output logic [WIDTH-1:0]     opnd_o,
    output logic                 qbit_o
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;

    always_comb begin
        acc_o  = acc_i;
        mc_o   = mc_i;
        opnd_o = opnd_i;
        qbit_o = 1'b0;
        // Partial remainder always stays below the divisor, so W bits hold it after the step.
        rem_sh = {acc_i[WIDTH-1:0], opnd_i[WIDTH-1]};
        diff   = {1'b0, rem_sh} - {2'b00, mc_i[WIDTH-1:0]};
        if (is_div) begin
            qbit_o = ~diff[WIDTH+1];
            acc_o  = {{WIDTH{1'b0}}, (qbit_o ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0])};
            opnd_o = {opnd_i[WIDTH-2:0], 1'b0};
        end else begin
            acc_o  = acc_i + (opnd_i[0] ? mc_i : {(2*WIDTH){1'b0}});
            mc_o   = {mc_i[2*WIDTH-2:0], 1'b0};
            opnd_o = {1'b0, opnd_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding HI/LO with a start/busy/done handshake.
// Define MULT_DIV_EARLY_OUT_EN to end RUN early on exhausted multipliers and zero divisors.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state, state_nx;
    ctl_t               ctl, ctl_in;
    op_e                op_in;
    logic               accept, last, early;
    logic [WIDTH-1:0]   a_mag, b_mag, a_raw;
    logic [2*WIDTH-1:0] acc, mc, acc_nx, mc_nx;
    logic [WIDTH-1:0]   opnd, opnd_nx;
    logic               qbit;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, hi_fix, lo_fix;

    assign op_in  = op_e'(op);
    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign last   = (cnt == CW'(WIDTH - 1));

    always_comb begin
        a_mag          = (op_signed(op_in) && a[WIDTH-1]) ? -a : a;
        b_mag          = (op_signed(op_in) && b[WIDTH-1]) ? -b : b;
        ctl_in.is_div  = op_is_div(op_in);
        ctl_in.b_zero  = (b == '0);
        ctl_in.neg_res = op_signed(op_in) && (a[WIDTH-1] ^ b[WIDTH-1]);
        ctl_in.neg_rem = op_signed(op_in) && a[WIDTH-1];
    end

    mult_div_step #(.WIDTH(WIDTH)) u_step (
        .is_div (ctl.is_div),
        .acc_i  (acc),
        .mc_i   (mc),
        .opnd_i (opnd),
        .acc_o  (acc_nx),
        .mc_o   (mc_nx),
        .opnd_o (opnd_nx),
        .qbit_o (qbit)
    );

`ifdef MULT_DIV_EARLY_OUT_EN
    // Once no multiplier bits remain, acc_nx already holds the full product.
    assign early = ctl.is_div ? ctl.b_zero : (opnd_nx == '0);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (last || early) state_nx = S_FIX;
            end
            S_FIX: begin
                busy     = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = start ? S_RUN : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Sign correction; a zero divisor bypasses it and returns the raw dividend.
    always_comb begin
        prod           = ctl.neg_res ? -acc : acc;
        quo            = ctl.neg_res ? -opnd : opnd;
        rem            = ctl.neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        {hi_fix, lo_fix} = prod;
        if (ctl.is_div) begin
            if (ctl.b_zero) begin
                hi_fix = a_raw;
                lo_fix = '1;
            end else begin
                hi_fix = rem;
                lo_fix = quo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl         <= '0;
            acc         <= '0;
            mc          <= '0;
            opnd        <= '0;
            a_raw       <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            ctl         <= ctl_in;
            acc         <= '0;
            mc          <= {{WIDTH{1'b0}}, (ctl_in.is_div ? b_mag : a_mag)};
            opnd        <= ctl_in.is_div ? a_mag : b_mag;
            a_raw       <= a;
            cnt         <= '0;
            div_by_zero <= 1'b0;
        end else if (state == S_RUN) begin
            acc  <= acc_nx;
            mc   <= mc_nx;
            opnd <= ctl.is_div ? {opnd_nx[WIDTH-1:1], qbit} : opnd_nx;
            cnt  <= cnt + 1'b1;
        end else if (state == S_FIX) begin
            hi          <= hi_fix;
            lo          <= lo_fix;
            div_by_zero <= ctl.is_div && ctl.b_zero;
        end
    end

endmodule
